despachador_colas: RTL and testbench

Weighted burst dispatcher that sits between the round-robin arbiter and the output port. It takes each grant (`selector`/`selector_enb`) from the arbiter and pops up to that queue's weight in words from the selected FIFO. It forwards the words through a one-word registered valid/ready output stage, then pulses `avanzar` so the arbiter moves to its next table entry.

---
 rtl/despachador_colas.sv | 153 +++++++++++++++
 tb/tb_despachador_colas.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/despachador_colas.sv
// despachador_colas: weighted burst dispatcher. It takes one arbiter grant and
// pops up to that queue's weight in words from the granted FWFT FIFO. The words
// go out through a one-word registered valid/ready stage. When the burst ends,
// avanzar pulses so the arbiter moves on.
//
// Optional feature (macro DESPACHADOR_SALTO_VACIO_EN): an empty or out-of-range
// grant is answered by avanzar in the grant cycle itself. Without the macro,
// such a grant takes the full IDLE->TRANSFER->RELEASE path with zero pops.
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-low reset
//   enb               global enable for grant acceptance and pops
//   selector          granted queue index
//   selector_enb      grant valid
//   pesos_cola        per-queue weights, queue i at [i*W +: W]
//   buf_empty         FIFO empty flags
//   buf_data          FIFO heads, queue i at [i*DATA_BITS +: DATA_BITS]
//   pop               one-hot FIFO read strobe (combinational)
//   avanzar           one-cycle grant-finished pulse (combinational)
//   data_out          registered output word
//   valid_out         registered output valid
//   ready_in          downstream ready
//   busy              state != IDLE
module despachador_colas #(
  parameter int unsigned QUEUE_QUANTITY = 4,
  parameter int unsigned DATA_BITS      = 8,
  parameter int unsigned MAX_WEIGHT     = 64,
  localparam int unsigned S = $clog2(QUEUE_QUANTITY),
  localparam int unsigned W = $clog2(MAX_WEIGHT)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                enb,
  input  logic [S-1:0]                        selector,
  input  logic                                selector_enb,
  input  logic [QUEUE_QUANTITY*W-1:0]         pesos_cola,
  input  logic [QUEUE_QUANTITY-1:0]           buf_empty,
  input  logic [QUEUE_QUANTITY*DATA_BITS-1:0] buf_data,
  output logic [QUEUE_QUANTITY-1:0]           pop,
  output logic                                avanzar,
  output logic [DATA_BITS-1:0]                data_out,
  output logic                                valid_out,
  input  logic                                ready_in,
  output logic                                busy
);

  typedef enum logic [1:0] {IDLE, TRANSFER, RELEASE} state_t;

  state_t               state;
  state_t               state_next;
  logic [S-1:0]         sel;
  logic [W-1:0]         restante;
  logic                 sel_empty;
  logic [DATA_BITS-1:0] sel_data;
  logic                 grant_in_range;
  logic                 grant_empty;
  logic [W-1:0]         grant_peso;
  logic                 grant_ok;
  logic                 grant_skip;
  logic                 load;
  logic                 slot_free;
  logic                 do_pop;

  // Queue lookups by index. Out-of-range indices read as empty queues.
  always_comb begin
    sel_empty      = 1'b1;
    sel_data       = '0;
    grant_in_range = 1'b0;
    grant_empty    = 1'b1;
    grant_peso     = '0;
    for (int unsigned i = 0; i < QUEUE_QUANTITY; i++) begin
      if (sel == S'(i)) begin
        sel_empty = buf_empty[i];
        sel_data  = buf_data[i*DATA_BITS +: DATA_BITS];
      end
      if (selector == S'(i)) begin
        grant_in_range = 1'b1;
        grant_empty    = buf_empty[i];
        grant_peso     = pesos_cola[i*W +: W];
      end
    end
  end

  assign grant_ok  = (state == IDLE) && enb && selector_enb;
  assign slot_free = !valid_out || ready_in;
  assign do_pop    = (state == TRANSFER) && enb && slot_free && !sel_empty &&
                     (restante != '0);

`ifdef DESPACHADOR_SALTO_VACIO_EN
  assign grant_skip = grant_ok && (!grant_in_range || grant_empty);
`else
  assign grant_skip = 1'b0;
`endif
  assign load = grant_ok && !grant_skip;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state logic. Early release waits for a free slot so that the empty
  // flag is not judged while a word is still pending downstream.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (load) state_next = TRANSFER;
      TRANSFER: begin
        if (enb) begin
          if (do_pop && (restante == W'(1)))           state_next = RELEASE;
          else if (!do_pop && slot_free && sel_empty)  state_next = RELEASE;
        end
      end
      RELEASE:  if (enb) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Combinational outputs decoded from state.
  always_comb begin
    pop     = '0;
    avanzar = grant_skip || ((state == RELEASE) && enb);
    for (int unsigned i = 0; i < QUEUE_QUANTITY; i++) begin
      if (do_pop && (sel == S'(i))) pop[i] = 1'b1;
    end
  end

  assign busy = (state != IDLE);

  // Grant latch, burst counter and output register. A zero weight counts as one.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sel       <= '0;
      restante  <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      if (load) begin
        sel      <= selector;
        restante <= (grant_peso == '0) ? W'(1) : grant_peso;
      end else if (do_pop) begin
        restante <= restante - W'(1);
      end
      if (do_pop) begin
        data_out  <= sel_data;
        valid_out <= 1'b1;
      end else if (valid_out && ready_in) begin
        valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_despachador_colas.sv
// Testbench for despachador_colas. Behavioural FIFO models feed the DUT. A
// scoreboard holds the words each grant should deliver, and every accepted
// output word is compared against it.
`timescale 1ns/1ps
module tb_despachador_colas;
  localparam int unsigned QQ = 4;
  localparam int unsigned DB = 8;
  localparam int unsigned MW = 64;
  localparam int unsigned W  = 6;
  localparam int unsigned S  = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           enb;
  logic [S-1:0]   selector;
  logic           selector_enb;
  logic [QQ*W-1:0]  pesos_cola;
  logic [QQ-1:0]    buf_empty;
  logic [QQ*DB-1:0] buf_data;
  logic [QQ-1:0]    pop;
  logic           avanzar;
  logic [DB-1:0]  data_out;
  logic           valid_out;
  logic           ready_in;
  logic           busy;

  always #5 clk = ~clk;

  despachador_colas #(.QUEUE_QUANTITY(QQ), .DATA_BITS(DB), .MAX_WEIGHT(MW)) dut (
    .clk(clk), .rst(rst), .enb(enb), .selector(selector), .selector_enb(selector_enb),
    .pesos_cola(pesos_cola), .buf_empty(buf_empty), .buf_data(buf_data), .pop(pop),
    .avanzar(avanzar), .data_out(data_out), .valid_out(valid_out), .ready_in(ready_in),
    .busy(busy)
  );

  int total = 0;
  int bad   = 0;
  logic [DB-1:0] fifo [QQ][$];
  logic [DB-1:0] sb [$];
  int cyc = 0;
  int n_pops, n_av, av_cyc, first_pop, g_cyc;
  int enb_off_start = 1000;
  int enb_off_len   = 0;
  int word_tag      = 1;
  logic [S-1:0] cur_sel = '0;
  bit sb_on = 1'b0;
  bit use_pat = 1'b0;
  bit prev_stall = 1'b0;
  logic [DB-1:0] prev_data = '0;
  logic [3:0] pat = 4'b1001;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < QQ; i++) begin
      buf_empty[i] = (fifo[i].size() == 0);
      buf_data[i*DB +: DB] = (fifo[i].size() != 0) ? fifo[i][0] : '0;
    end
  endtask

  task automatic fill(input int q, input int n);
    for (int i = 0; i < n; i++) begin
      fifo[q].push_back(DB'(word_tag));
      word_tag++;
    end
    refresh();
  endtask

  task automatic set_peso(input int q, input int w);
    pesos_cola[q*W +: W] = W'(w);
  endtask

  // One clock cycle: sample outputs before the edge, then update the FIFOs after it.
  task automatic ciclo();
    logic [QQ-1:0] p;
    logic [DB-1:0] e;
    #1;
    p = pop;
    if (sb_on) begin
      if (!enb) check("pop_while_enb0", 32'(pop), 0);
      if (prev_stall) begin
        check("hold_valid", 32'(valid_out), 1);
        check("hold_data", 32'(data_out), 32'(prev_data));
      end
      if (pop != '0) begin
        check("pop_onehot", 32'($onehot(pop)), 1);
        check("pop_target", 32'(pop & ~(QQ'(1) << cur_sel)), 0);
        if (n_pops == 0) first_pop = cyc;
        n_pops++;
      end
      if (avanzar) begin
        n_av++;
        if (av_cyc < 0) av_cyc = cyc;
      end
      if (valid_out && ready_in) begin
        if (sb.size() == 0) check("extra_word", 32'(data_out), 32'hFFFF_FFFF);
        else begin
          e = sb.pop_front();
          check("word", 32'(data_out), 32'(e));
        end
      end
      prev_stall = valid_out && !ready_in;
      prev_data  = data_out;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < QQ; i++) if (p[i] && fifo[i].size() > 0) void'(fifo[i].pop_front());
    refresh();
    cyc++;
    @(negedge clk);
  endtask

  // Issue one grant, hold it until avanzar, drain the output, then check the burst.
  task automatic run_grant(input int q, input int exp_turn, input string nm);
    int n;
    int w;
    w = int'(pesos_cola[q*W +: W]);
    if (w == 0) w = 1;
    n = (fifo[q].size() < w) ? fifo[q].size() : w;
    for (int i = 0; i < n; i++) sb.push_back(fifo[q][i]);
    cur_sel = S'(q);
    n_pops = 0; n_av = 0; av_cyc = -1; first_pop = -1; g_cyc = cyc;
    selector = S'(q);
    selector_enb = 1'b1;
    for (int k = 0; k < 300 && av_cyc < 0; k++) begin
      enb = !(k >= enb_off_start && k < enb_off_start + enb_off_len);
      ready_in = use_pat ? pat[k % 4] : 1'b1;
      ciclo();
    end
    selector_enb = 1'b0;
    enb = 1'b1;
    ready_in = 1'b1;
    if (av_cyc < 0) check({nm, "_avanzar_timeout"}, 0, 1);
    for (int k = 0; k < 100 && (sb.size() > 0 || valid_out); k++) ciclo();
    check({nm, "_left"}, 32'(sb.size()), 0);
    check({nm, "_pops"}, 32'(n_pops), 32'(n));
    check({nm, "_avanzar_cnt"}, 32'(n_av), 1);
    if (exp_turn >= 0) check({nm, "_turn"}, 32'(av_cyc - g_cyc), 32'(exp_turn));
    if (n > 0) check({nm, "_first_pop"}, 32'(first_pop - g_cyc), 1);
    check({nm, "_busy_idle"}, 32'(busy), 0);
  endtask

  initial begin
    rst = 1'b0; enb = 1'b1; ready_in = 1'b1; selector_enb = 1'b0; selector = '0;
    pesos_cola = '0; buf_empty = '1; buf_data = '0;
    @(negedge clk);
    // Reset with random inputs.
    for (int r = 0; r < 4; r++) begin
      selector = S'($urandom); selector_enb = 1'($urandom); enb = 1'($urandom);
      buf_empty = QQ'($urandom); buf_data = (QQ*DB)'($urandom);
      pesos_cola = (QQ*W)'($urandom); ready_in = 1'($urandom);
      @(posedge clk);
      #1;
      check("rst_pop", 32'(pop), 0);
      check("rst_avanzar", 32'(avanzar), 0);
      check("rst_valid", 32'(valid_out), 0);
      check("rst_data", 32'(data_out), 0);
      check("rst_busy", 32'(busy), 0);
      @(negedge clk);
    end
    rst = 1'b1; enb = 1'b1; ready_in = 1'b1; selector_enb = 1'b0; selector = '0;
    pesos_cola = '0;
    refresh();
    sb_on = 1'b1;
    ciclo();

    fill(2, 10); set_peso(2, 3);
    run_grant(2, 4, "full");

    fill(1, 2); set_peso(1, 5);
    run_grant(1, 4, "early");

`ifdef DESPACHADOR_SALTO_VACIO_EN
    run_grant(3, 0, "empty");
`else
    run_grant(3, 2, "empty");
`endif

    fill(3, 6); set_peso(3, 4); use_pat = 1'b1;
    run_grant(3, -1, "backpressure");
    use_pat = 1'b0;

    fill(0, 3); set_peso(0, 0);
    run_grant(0, 2, "weight0");

    fill(1, 8); set_peso(1, 6); enb_off_start = 3; enb_off_len = 5;
    run_grant(1, 12, "enb_gate");
    enb_off_start = 1000; enb_off_len = 0;

    fill(0, 70); set_peso(0, 63);
    run_grant(0, 64, "max_weight");

    // Reset in the middle of a burst discards the pending word.
    sb_on = 1'b0;
    set_peso(2, 5); selector = 2'd2; selector_enb = 1'b1;
    ciclo(); ciclo(); ciclo();
    rst = 1'b0; selector_enb = 1'b0;
    ciclo();
    check("midrst_busy", 32'(busy), 0);
    check("midrst_valid", 32'(valid_out), 0);
    check("midrst_pop", 32'(pop), 0);
    check("midrst_data", 32'(data_out), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
